// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: single-port word memory with byte-lane writes,
// programmable wait states and a two-cycle ERROR response for illegal transfers.
module ahb_lite_mem_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int IDX_W  = ADDR_WIDTH - LANE_W;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(MEM_DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_e;

  function automatic logic [NBYTES-1:0] lane_strobe(input logic [2:0] size,
                                                    input logic [LANE_W-1:0] off);
    logic [NBYTES-1:0] base;
    base = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < (1 << size)) base[i] = 1'b1;
    end
    return base << off;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [LANE_W-1:0] off);
    logic [LANE_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANE_W; i++) begin
      if (i < int'(size)) m[i] = 1'b1;
    end
    return |(off & m);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  hreadyout_q, hreadyout_d;
  logic [1:0]            hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [MEM_AW-1:0]     dp_idx_q, dp_idx_d;
  logic [NBYTES-1:0]     dp_strb_q, dp_strb_d;

  logic                  accept_s, xfer_err_s, mem_we_s, rd_load_s;
  logic [IDX_W-1:0]      word_idx_s;
  logic [MEM_AW-1:0]     rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  unused_s;

  assign unused_s   = ^{HBURST, HTRANS[0]};
  assign word_idx_s = HADDR[ADDR_WIDTH-1:LANE_W];
  // Inputs are only looked at while this slave is ready.
  assign accept_s   = HSEL && HREADY && HTRANS[1] && hreadyout_q;
  assign xfer_err_s = ({1'b0, word_idx_s} >= DEPTH_LIM) || (int'(HSIZE) > LANE_W) ||
                      misaligned(HSIZE, HADDR[LANE_W-1:0]);
  assign mem_we_s   = dp_valid_q && dp_write_q && hreadyout_q && !HRESET;

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

  // Next-state and registered-output decode of the transfer FSM.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hreadyout_d = 1'b1;
    hresp_d     = RESP_OKAY;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_idx_d    = dp_idx_q;
    dp_strb_d   = dp_strb_q;
    rd_load_s   = 1'b0;
    rd_idx_s    = dp_idx_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d    = S_IDLE;
        dp_valid_d = 1'b0;
        if (accept_s) begin
          if (xfer_err_s) begin
            state_d     = S_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = RESP_ERROR;
          end else begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_idx_d   = word_idx_s[MEM_AW-1:0];
            dp_strb_d  = lane_strobe(HSIZE, HADDR[LANE_W-1:0]);
            if (WAIT_STATES > 0) begin
              state_d     = S_WAIT;
              wait_cnt_d  = WAIT_INIT;
              hreadyout_d = 1'b0;
            end else begin
              rd_load_s = !HWRITE;
              rd_idx_s  = word_idx_s[MEM_AW-1:0];
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        hreadyout_d = 1'b0;
        if (wait_cnt_q == 4'd0) begin
          state_d     = S_IDLE;
          hreadyout_d = 1'b1;
          rd_load_s   = !dp_write_q;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
        hresp_d = RESP_ERROR;
      end
      default: begin
        state_d    = S_IDLE;
        dp_valid_d = 1'b0;
      end
    endcase
  end

  // Read word, with bytes being written at this same edge forwarded in.
  always_comb begin
    rd_word_s = mem_q[rd_idx_s];
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_we_s && (dp_idx_q == rd_idx_s) && dp_strb_q[i]) begin
        rd_word_s[8*i +: 8] = HWDATA[8*i +: 8];
      end else begin
        rd_word_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
    hrdata_d = rd_load_s ? rd_word_s : hrdata_q;
  end

  // Control and output registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      hrdata_q    <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_idx_q    <= '0;
      dp_strb_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_idx_q    <= dp_idx_d;
      dp_strb_q   <= dp_strb_d;
    end
  end

  // Memory array is never reset; writes land on the completing edge.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_we_s && dp_strb_q[i]) begin
        mem_q[dp_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one zero-wait and one three-wait instance,
// each scored against a word-array model of the AHB transfer rules.
module tb_ahb_lite_mem_slave;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int NW    = 32;   // model covers words 0..NW-1

  typedef struct {
    bit              active;
    bit              sel;
    logic [1:0]      trans;
    bit              wr;
    logic [AW-1:0]   addr;
    logic [2:0]      size;
    logic [DW-1:0]   wdata;
  } xfer_t;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic [1:0]          hreset, hsel, hwrite;
  logic [1:0][AW-1:0]  haddr;
  logic [1:0][1:0]     htrans;
  logic [1:0][2:0]     hsize, hburst;
  logic [1:0][DW-1:0]  hwdata;
  wire  [1:0]          hready_w, hreadyout_w;
  wire  [1:0][1:0]     hresp_w;
  wire  [1:0][DW-1:0]  hrdata_w;
  assign hready_w = hreadyout_w;

  ahb_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
    .HREADY(hready_w[0]), .HREADYOUT(hreadyout_w[0]), .HRESP(hresp_w[0]), .HRDATA(hrdata_w[0]));

  ahb_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .HCLK(hclk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
    .HREADY(hready_w[1]), .HREADYOUT(hreadyout_w[1]), .HRESP(hresp_w[1]), .HRDATA(hrdata_w[1]));

  int errors = 0;
  int checks = 0;
  xfer_t xq[$];
  logic [DW-1:0] model [2][NW];
  logic [DW-1:0] last_rd [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit exp_err(input xfer_t t);
    int nb;
    nb = 1 << t.size;
    if (nb > DW / 8) return 1'b1;
    if ((int'(t.addr) % nb) != 0) return 1'b1;
    if ((int'(t.addr) / (DW / 8)) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic xfer_t mk(input bit wr, input logic [AW-1:0] a, input logic [2:0] s,
                               input logic [DW-1:0] w);
    xfer_t t;
    t.active = 1'b1; t.sel = 1'b1; t.trans = 2'b10;
    t.wr = wr; t.addr = a; t.size = s; t.wdata = w;
    return t;
  endfunction

  function automatic xfer_t mk_gap();
    xfer_t t;
    t.active = 1'b0;
    t.sel    = 1'($urandom_range(0, 1));
    t.trans  = t.sel ? 2'($urandom_range(0, 1)) : 2'b10;
    t.wr     = 1'($urandom_range(0, 1));
    t.addr   = AW'($urandom_range(0, 127));
    t.size   = 3'd2;
    t.wdata  = $urandom;
    return t;
  endfunction

  function automatic xfer_t mk_idle();
    xfer_t t;
    t = mk_gap();
    t.sel = 1'b0; t.trans = 2'b00; t.wr = 1'b0;
    return t;
  endfunction

  // Drives everything queued in xq onto DUT d with AHB pipelining and scores each data phase.
  task automatic run_queue(input int d, input string tag);
    xfer_t ap, dp;
    bit dp_v, first, e;
    int waits, budget, idx, nb, lane;
    logic [DW-1:0] expw;
    logic [1:0] expr;
    dp_v = 1'b0; first = 1'b0; waits = 0; budget = 5000;
    while ((xq.size() != 0 || dp_v) && budget > 0) begin
      @(negedge hclk);
      budget--;
      if (dp_v) begin
        if (first) begin
          hwdata[d] = dp.wdata;
          first = 1'b0;
        end
        e = exp_err(dp);
        expr = e ? 2'b01 : 2'b00;
        checks++;
        if (hresp_w[d] !== expr) begin
          errors++;
          $display("FAIL %s hresp dut%0d addr=%h: got %b expected %b", tag, d, dp.addr, hresp_w[d], expr);
        end
        if (hreadyout_w[d] !== 1'b1) begin
          waits++;
          checks++;
          if (hrdata_w[d] !== last_rd[d]) begin
            errors++;
            $display("FAIL %s hrdata_hold dut%0d: got %h expected %h", tag, d, hrdata_w[d], last_rd[d]);
          end
          hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = 1'($urandom_range(0, 1));
          haddr[d] = AW'($urandom_range(0, 127)) & 16'hFFFC; hsize[d] = 3'd2;
        end else begin
          checks++;
          if (waits != (e ? 1 : ws_of(d))) begin
            errors++;
            $display("FAIL %s stall_cycles dut%0d addr=%h: got %0d expected %0d", tag, d, dp.addr, waits, e ? 1 : ws_of(d));
          end
          idx = int'(dp.addr) / 4;
          expw = (!e && !dp.wr) ? model[d][idx] : last_rd[d];
          checks++;
          if (hrdata_w[d] !== expw) begin
            errors++;
            $display("FAIL %s hrdata dut%0d addr=%h wr=%0d: got %h expected %h", tag, d, dp.addr, dp.wr, hrdata_w[d], expw);
          end
          last_rd[d] = expw;
          if (!e && dp.wr) begin
            nb = 1 << dp.size;
            for (int b = 0; b < nb; b++) begin
              lane = (int'(dp.addr) % 4) + b;
              model[d][idx][lane*8 +: 8] = dp.wdata[lane*8 +: 8];
            end
          end
          dp_v = 1'b0;
        end
      end else begin
        checks++;
        if (hreadyout_w[d] !== 1'b1 || hresp_w[d] !== 2'b00) begin
          errors++;
          $display("FAIL %s idle_phase dut%0d: got ready=%b resp=%b expected ready=1 resp=00", tag, d, hreadyout_w[d], hresp_w[d]);
        end
      end
      if (hreadyout_w[d] === 1'b1) begin
        ap = (xq.size() != 0) ? xq.pop_front() : mk_idle();
        hsel[d] = ap.sel; htrans[d] = ap.trans; hwrite[d] = ap.wr;
        haddr[d] = ap.addr; hsize[d] = ap.size; hburst[d] = 3'($urandom_range(0, 1));
        if (ap.active) begin
          dp = ap; dp_v = 1'b1; first = 1'b1; waits = 0;
        end
      end
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL %s timeout dut%0d: got no completion expected completion within budget", tag, d);
    end
  endtask

  task automatic test_reset();
    hreset = 2'b11; hsel = 2'b00; hwrite = 2'b00; haddr = '0; htrans = '0;
    hsize = '0; hburst = '0; hwdata = '0;
    repeat (2) @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (hreadyout_w[d] !== 1'b1 || hresp_w[d] !== 2'b00 || hrdata_w[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got ready=%b resp=%b rdata=%h expected 1/00/0", d, hreadyout_w[d], hresp_w[d], hrdata_w[d]);
      end
      last_rd[d] = 32'h0;
    end
    hreset = 2'b00;
  endtask

  task automatic test_init_fill();
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < NW; w++) xq.push_back(mk(1'b1, AW'(w * 4), 3'd2, $urandom));
      for (int w = 0; w < NW; w++) xq.push_back(mk(1'b0, AW'(w * 4), 3'd2, $urandom));
      run_queue(d, "init_fill");
    end
  endtask

  task automatic test_back_to_back();
    xq.push_back(mk(1'b1, 16'h0010, 3'd2, 32'hDEADBEEF));
    xq.push_back(mk(1'b0, 16'h0010, 3'd2, 32'h0));
    run_queue(0, "back_to_back");
    @(negedge hclk);
    checks++;
    if (hrdata_w[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_readback: got %h expected deadbeef", hrdata_w[0]);
    end
  endtask

  task automatic test_wait_states();
    xq.push_back(mk(1'b0, 16'h0010, 3'd2, 32'h0));
    xq.push_back(mk(1'b1, 16'h0014, 3'd2, 32'hCAFEF00D));
    xq.push_back(mk(1'b0, 16'h0014, 3'd2, 32'h0));
    run_queue(1, "wait_states");
  endtask

  task automatic test_byte_write();
    for (int d = 0; d < 2; d++) begin
      xq.push_back(mk(1'b1, 16'h0010, 3'd2, 32'h11223344));
      xq.push_back(mk(1'b1, 16'h0013, 3'd0, 32'hAA5A5A5A));
      xq.push_back(mk(1'b0, 16'h0010, 3'd2, 32'h0));
      run_queue(d, "byte_write");
      @(negedge hclk);
      checks++;
      if (hrdata_w[d] !== 32'hAA223344) begin
        errors++;
        $display("FAIL byte_merge dut%0d: got %h expected aa223344", d, hrdata_w[d]);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int d = 0; d < 2; d++) begin
      xq.push_back(mk(1'b1, 16'h1000, 3'd2, $urandom));
      xq.push_back(mk(1'b0, 16'h1000, 3'd2, 32'h0));
      xq.push_back(mk(1'b1, 16'hFFFC, 3'd2, $urandom));
      xq.push_back(mk(1'b0, 16'h0000, 3'd2, 32'h0));
      xq.push_back(mk(1'b0, 16'h007C, 3'd2, 32'h0));
      run_queue(d, "out_of_range");
    end
  endtask

  task automatic test_misaligned();
    for (int d = 0; d < 2; d++) begin
      xq.push_back(mk(1'b0, 16'h0001, 3'd1, 32'h0));
      xq.push_back(mk(1'b0, 16'h0004, 3'd2, 32'h0));
      xq.push_back(mk(1'b1, 16'h0003, 3'd1, $urandom));
      xq.push_back(mk(1'b1, 16'h0008, 3'd3, $urandom));
      xq.push_back(mk(1'b1, 16'h0006, 3'd1, 32'h77665544));
      xq.push_back(mk(1'b0, 16'h0004, 3'd2, 32'h0));
      run_queue(d, "misaligned");
    end
  endtask

  task automatic test_reset_abort();
    @(negedge hclk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 16'h0020; hsize[1] = 3'd2;
    @(negedge hclk);
    hwdata[1] = ~model[1][8]; htrans[1] = 2'b00;
    checks++;
    if (hreadyout_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait1: got ready=%b expected 0", hreadyout_w[1]);
    end
    @(negedge hclk);
    checks++;
    if (hreadyout_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait2: got ready=%b expected 0", hreadyout_w[1]);
    end
    hreset[1] = 1'b1;
    @(negedge hclk);
    hreset[1] = 1'b0;
    checks++;
    if (hreadyout_w[1] !== 1'b1 || hresp_w[1] !== 2'b00 || hrdata_w[1] !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: got ready=%b resp=%b rdata=%h expected 1/00/0", hreadyout_w[1], hresp_w[1], hrdata_w[1]);
    end
    last_rd[1] = 32'h0;
    xq.push_back(mk(1'b0, 16'h0020, 3'd2, 32'h0));
    xq.push_back(mk(1'b0, 16'h0010, 3'd2, 32'h0));
    run_queue(1, "reset_abort");
  endtask

  task automatic test_random();
    int r;
    logic [2:0] sz;
    logic [AW-1:0] a;
    xfer_t t;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 15) begin
          xq.push_back(mk_gap());
        end else begin
          sz = (r < 20) ? 3'd3 : 3'($urandom_range(0, 2));
          a  = AW'($urandom_range(0, 127));
          if (r >= 28) a = a & ~AW'((1 << sz) - 1);
          if (r >= 93) a = 16'h1000 | (a & 16'h0FFC);
          t = mk(1'($urandom_range(0, 1)), a, sz, $urandom);
          if ($urandom_range(0, 3) == 0) t.trans = 2'b11;
          xq.push_back(t);
        end
      end
      run_queue(d, "random");
      for (int w = 0; w < NW; w++) xq.push_back(mk(1'b0, AW'(w * 4), 3'd2, 32'h0));
      run_queue(d, "random_sweep");
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_back_to_back();
    test_wait_states();
    test_byte_write();
    test_out_of_range();
    test_misaligned();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit expected test completion");
    $fatal(1);
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, byte address width of HADDR.
REQ-002 Parameter DATA_WIDTH, default 32, HWDATA/HRDATA width; legal values 32 and 64 only.
REQ-003 Parameter MEM_DEPTH, default 1024, number of DATA_WIDTH words; MEM_DEPTH*DATA_WIDTH/8 SHALL NOT exceed 2**ADDR_WIDTH.
REQ-004 Parameter WAIT_STATES, default 0, range 0..15, wait cycles inserted per OKAY transfer.
REQ-005 Port HCLK, in, 1, sole clock; all state updates on its rising edge.
REQ-006 Port HRESET, in, 1, synchronous active-high reset.
REQ-007 Port HSEL, in, 1, slave select.
REQ-008 Port HADDR, in, ADDR_WIDTH, byte address.
REQ-009 Port HTRANS, in, 2, transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-010 Port HWRITE, in, 1, 1=write, 0=read.
REQ-011 Port HSIZE, in, 3, transfer size: 0=byte, 1=half, 2=word, 3=dword.
REQ-012 Port HBURST, in, 3, burst type; accepted, not decoded (every beat carries its own HADDR).
REQ-013 Port HWDATA, in, DATA_WIDTH, write data, valid in the data phase.
REQ-014 Port HREADY, in, 1, bus-level ready (previous transfer complete).
REQ-015 Port HREADYOUT, out, 1, slave ready; 0 extends the current data phase.
REQ-016 Port HRESP, out, 2, response: OKAY=00, ERROR=01; RETRY/SPLIT never driven.
REQ-017 Port HRDATA, out, DATA_WIDTH, read data.

Function
REQ-018 An address phase SHALL be accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE SHALL be latched at that edge.
REQ-019 On IDLE/BUSY or HSEL=0 with HREADY=1, the slave SHALL give a zero-wait OKAY data phase and SHALL NOT access memory.
REQ-020 A transfer SHALL be flagged ERROR if the word index HADDR>>log2(DATA_WIDTH/8) >= MEM_DEPTH, if 2**HSIZE > DATA_WIDTH/8, or if HADDR is not aligned to 2**HSIZE.
REQ-021 FSM states: IDLE, WAIT, ERR1, ERR2; reset state IDLE.
REQ-022 IDLE -> WAIT on an accepted OKAY transfer when WAIT_STATES>0; the transfer completes in IDLE when WAIT_STATES=0.
REQ-023 WAIT: HREADYOUT=0, HRESP=OKAY; the wait counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0, next cycle HREADYOUT=1 (completion), then back to IDLE or a new transfer.
REQ-024 An accepted ERROR transfer -> ERR1 (HREADYOUT=0, HRESP=01) -> ERR2 (HREADYOUT=1, HRESP=01) -> IDLE; no wait states and no memory access.
REQ-025 A write SHALL update memory at the completing edge (HREADYOUT=1) using HWDATA of that cycle; only byte lanes selected by HSIZE and HADDR low bits are written.
REQ-026 A read SHALL drive HRDATA = memory[latched index] in the completing cycle; a read directly after a write to the same word SHALL return the new data.
REQ-027 HRDATA SHALL hold its last read value in all non-completing cycles.
REQ-028 A transfer accepted in the completing cycle of the previous one SHALL be pipelined with no bubble (back-to-back zero-wait throughput of 1 transfer/cycle).
REQ-029 Inputs sampled while HREADYOUT=0 SHALL be ignored.

Reset
REQ-030 With HRESET=1 at a rising edge: FSM=IDLE, wait counter=0, HREADYOUT=1, HRESP=00, HRDATA=0.
REQ-031 Reset during WAIT/ERR1/ERR2 SHALL abort the transfer; a pending write SHALL be discarded.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 WAIT_STATES=0: write 0xDEADBEEF to 0x0010, then read 0x0010 back-to-back -> HREADYOUT stays 1, HRESP=00, HRDATA=0xDEADBEEF.
REQ-034 WAIT_STATES=3: read -> exactly 3 cycles HREADYOUT=0, then 1 completion cycle with HRESP=00.
REQ-035 Byte write 0xAA to 0x0013 over word 0x11223344 -> read of 0x0010 returns 0xAA223344.
REQ-036 Access to word index MEM_DEPTH (0x1000 at defaults) -> HRESP=01 for 2 cycles, HREADYOUT 0 then 1; memory unchanged.
REQ-037 Misaligned halfword at 0x0001 -> two-cycle ERROR; following NONSEQ to 0x0004 -> OKAY.
REQ-038 HRESET asserted in the 2nd WAIT cycle of a write -> next cycle HREADYOUT=1, HRESP=00; target word unchanged on readback.
